// File: rtl/spi_pkg.sv
// ============================================================
// spi_pkg: shared state encoding and SPICR bit positions for the SPI transfer sequencer
// Revision 1.0
// ============================================================
`default_nettype none

package spi_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SETUP   = 3'd1,
      S_LOAD    = 3'd2,
      S_SHIFT   = 3'd3,
      S_WAIT_TX = 3'd4,
      S_HOLD    = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   localparam int CPHA_BIT = 0;
   localparam int CPOL_BIT = 1;
   localparam int EN_BIT   = 2;

endpackage

`default_nettype wire

// File: rtl/spi_guard_cnt.sv
// ============================================================
// spi_guard_cnt: loadable down-counter with zero flag, timing CS setup and hold
// Revision 1.0
// ============================================================
`default_nettype none

module spi_guard_cnt
   import spi_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (ld)
         cnt <= ld_val;
      else if (dec && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
// ============================================================
// spi_xfer_ctrl: SPI master transfer sequencer; define SPI_CS_GUARD_EN for GUARD_CYC-long CS setup/hold
// Revision 1.0
// ============================================================
`default_nettype none

module spi_xfer_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int LEN_W     = 4,
   parameter int GUARD_CYC = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       spicr,
   input  logic [LEN_W-1:0] xfer_len,
   input  logic             sample_clk,
   input  logic             shift_clk,
   input  logic             tx_valid,
   output logic [2:0]       spicr_q,
   output logic             baud_en,
   output logic             cs_n,
   output logic             load,
   output logic             tx_req,
   output logic             rx_valid,
   output logic             busy,
   output logic             done
);

   localparam int               BIT_W    = $clog2(DATA_W + 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] BIT_FULL = BIT_W'(DATA_W);

   generate
      if (GUARD_CYC < 1 || GUARD_CYC > 15) begin : g_guard_range_err
         $error("GUARD_CYC must be within 1..15");
      end
   endgenerate

   state_t           state, state_d;
   logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
   logic [LEN_W-1:0] byte_cnt, byte_cnt_d;
   logic [2:0]       spicr_d;
   logic             byte_end;
   logic             rx_valid_d;
   logic             guard_zero;

`ifdef SPI_CS_GUARD_EN
   localparam logic [3:0] GUARD_INIT = 4'(GUARD_CYC - 1);
   logic guard_ld, guard_dec;

   // Reload on entry to either guard state so SETUP and HOLD share one counter.
   assign guard_ld  = ((state_d == S_SETUP) && (state != S_SETUP)) ||
                      ((state_d == S_HOLD)  && (state != S_HOLD));
   assign guard_dec = (state == S_SETUP) || (state == S_HOLD);

   spi_guard_cnt #(.W(4)) u_guard_cnt (
      .clk    (clk),
      .reset  (reset),
      .ld     (guard_ld),
      .ld_val (GUARD_INIT),
      .dec    (guard_dec),
      .zero   (guard_zero)
   );
`else
   assign guard_zero = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         bit_cnt  <= '0;
         byte_cnt <= '0;
      end else begin
         state    <= state_d;
         bit_cnt  <= bit_cnt_d;
         byte_cnt <= byte_cnt_d;
      end
   end

   always_comb begin
      state_d    = state;
      bit_cnt_d  = bit_cnt;
      byte_cnt_d = byte_cnt;
      spicr_d    = spicr_q;
      rx_valid_d = 1'b0;
      byte_end   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && spicr[EN_BIT]) begin
               state_d    = S_SETUP;
               spicr_d    = spicr;
               byte_cnt_d = xfer_len;
               bit_cnt_d  = '0;
            end
         end
         S_SETUP: if (guard_zero) state_d = S_LOAD;
         S_LOAD:  state_d = S_SHIFT;
         S_SHIFT: begin
            // Sample wins over a coincident shift pulse.
            if (sample_clk) begin
               if (bit_cnt < BIT_FULL)
                  bit_cnt_d = bit_cnt + 1'b1;
               if (bit_cnt == BIT_LAST) begin
                  rx_valid_d = 1'b1;
                  byte_end   = spicr_q[CPHA_BIT];
               end
            end else if (shift_clk && !spicr_q[CPHA_BIT] && (bit_cnt == BIT_FULL)) begin
               byte_end = 1'b1;
            end
            if (byte_end) begin
               bit_cnt_d = '0;
               if (byte_cnt == '0) begin
                  state_d = S_HOLD;
               end else begin
                  byte_cnt_d = byte_cnt - 1'b1;
                  state_d    = S_WAIT_TX;
               end
            end
         end
         S_WAIT_TX: if (tx_valid) state_d = S_LOAD;
         S_HOLD:    if (guard_zero) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         spicr_q  <= '0;
         cs_n     <= 1'b1;
         baud_en  <= 1'b0;
         load     <= 1'b0;
         tx_req   <= 1'b0;
         rx_valid <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         spicr_q  <= spicr_d;
         cs_n     <= (state_d == S_IDLE) || (state_d == S_DONE);
         baud_en  <= (state_d == S_SHIFT);
         load     <= (state_d == S_LOAD);
         tx_req   <= (state_d == S_LOAD) && (byte_cnt_d != '0);
         rx_valid <= rx_valid_d;
         busy     <= (state_d != S_IDLE) && (state_d != S_DONE);
         done     <= (state_d == S_DONE);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
// ============================================================
// tb_spi_xfer_ctrl: self-checking bench; acts as phase/polarity block and predicts each transaction cycle by cycle
// Revision 1.0
// ============================================================
`default_nettype none

module tb_spi_xfer_ctrl;

   localparam int DATA_W    = 8;
   localparam int LEN_W     = 4;
   localparam int GUARD_CYC = 2;
`ifdef SPI_CS_GUARD_EN
   localparam int GUARD = GUARD_CYC;
`else
   localparam int GUARD = 1;
`endif

   logic             clk = 1'b0;
   logic             reset, start, sample_clk, shift_clk, tx_valid;
   logic [2:0]       spicr;
   logic [LEN_W-1:0] xfer_len;
   logic [2:0]       spicr_q;
   logic             baud_en, cs_n, load, tx_req, rx_valid, busy, done;

   always #5 clk = ~clk;

   spi_xfer_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W), .GUARD_CYC(GUARD_CYC)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .spicr      (spicr),
      .xfer_len   (xfer_len),
      .sample_clk (sample_clk),
      .shift_clk  (shift_clk),
      .tx_valid   (tx_valid),
      .spicr_q    (spicr_q),
      .baud_en    (baud_en),
      .cs_n       (cs_n),
      .load       (load),
      .tx_req     (tx_req),
      .rx_valid   (rx_valid),
      .busy       (busy),
      .done       (done)
   );

   int       errors = 0;
   int       checks = 0;
   int       cyc    = 0;
   logic [2:0] cur_s = 3'b000;
   bit       noisy  = 1'b0;
   int       n_load = 0, n_txreq = 0, n_rx = 0, n_done = 0;

   always @(negedge clk) begin
      if (load)     n_load  <= n_load + 1;
      if (tx_req)   n_txreq <= n_txreq + 1;
      if (rx_valid) n_rx    <= n_rx + 1;
      if (done)     n_done  <= n_done + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic e_csn, input logic e_baud,
                          input logic e_load, input logic e_txreq, input logic e_rx,
                          input logic e_busy, input logic e_done);
      chk({tag, ".cs_n"},     32'(cs_n),     32'(e_csn));
      chk({tag, ".baud_en"},  32'(baud_en),  32'(e_baud));
      chk({tag, ".load"},     32'(load),     32'(e_load));
      chk({tag, ".tx_req"},   32'(tx_req),   32'(e_txreq));
      chk({tag, ".rx_valid"}, 32'(rx_valid), 32'(e_rx));
      chk({tag, ".busy"},     32'(busy),     32'(e_busy));
      chk({tag, ".done"},     32'(done),     32'(e_done));
      chk({tag, ".spicr_q"},  32'(spicr_q),  32'(cur_s));
   endtask

   // One clock: drive pulses (and garbage requests while busy), then sample 1 ns after the edge.
   task automatic tick(input logic smp, input logic shf);
      sample_clk = smp;
      shift_clk  = shf;
      if (noisy) begin
         start    = 1'($urandom % 2);
         spicr    = 3'($urandom);
         xfer_len = LEN_W'($urandom);
      end
      @(posedge clk);
      #1;
      cyc++;
      sample_clk = 1'b0;
      shift_clk  = 1'b0;
      start      = 1'b0;
   endtask

   // Outside SHIFT, stray phase pulses must have no effect.
   task automatic idle_tick();
      int r;
      r = int'($urandom % 3);
      tick(r == 1, r == 2);
   endtask

   task automatic gap();
      int n;
      n = int'($urandom % 3);
      repeat (n) begin
         tick(1'b0, 1'b0);
         chk_out("gap", 0, 1, 0, 0, 0, 1, 0);
      end
   endtask

   // Drives one byte of phase pulses starting in the first SHIFT cycle.
   task automatic shift_byte(input logic cpha);
      for (int k = 1; k <= DATA_W; k++) begin
         if (cpha) begin
            gap();
            tick(1'b0, 1'b1);
            chk_out("shf_lead", 0, 1, 0, 0, 0, 1, 0);
         end
         gap();
         tick(1'b1, 1'b0);
         if (k < DATA_W)
            chk_out("smp", 0, 1, 0, 0, 0, 1, 0);
         else
            chk_out("smp_last", 0, !cpha, 0, 0, 1, 1, 0);
         if (!cpha && k < DATA_W) begin
            gap();
            tick(1'b0, 1'b1);
            chk_out("shf_trail", 0, 1, 0, 0, 0, 1, 0);
         end
      end
      if (!cpha) begin
         gap();
         tick(1'b0, 1'b1);
         chk_out("byte_end", 0, 0, 0, 0, 0, 1, 0);
      end
   endtask

   // stall < 0 picks a random underrun of 0..3 cycles before each following byte.
   task automatic run_xfer(input logic [2:0] s, input int len, input int stall, input bit noise);
      int l0, t0, r0, d0, st;
      l0 = n_load; t0 = n_txreq; r0 = n_rx; d0 = n_done;
      start    = 1'b1;
      spicr    = s;
      xfer_len = LEN_W'(len);
      cur_s    = s;
      tx_valid = 1'b1;
      tick(1'b0, 1'b0);
      noisy = noise;
      chk_out("setup", 0, 0, 0, 0, 0, 1, 0);
      repeat (GUARD - 1) begin
         idle_tick();
         chk_out("setup", 0, 0, 0, 0, 0, 1, 0);
      end
      for (int b = 0; b <= len; b++) begin
         idle_tick();
         chk_out("load", 0, 0, 1, (b < len), 0, 1, 0);
         idle_tick();
         chk_out("shift0", 0, 1, 0, 0, 0, 1, 0);
         shift_byte(s[0]);
         if (b < len) begin
            st = (stall < 0) ? int'($urandom % 4) : stall;
            if (st > 0) tx_valid = 1'b0;
            repeat (st) begin
               idle_tick();
               chk_out("wait_tx", 0, 0, 0, 0, 0, 1, 0);
            end
            tx_valid = 1'b1;
         end
      end
      repeat (GUARD - 1) begin
         idle_tick();
         chk_out("hold", 0, 0, 0, 0, 0, 1, 0);
      end
      idle_tick();
      chk_out("done", 1, 0, 0, 0, 0, 0, 1);
      noisy = 1'b0;
      idle_tick();
      chk_out("idle", 1, 0, 0, 0, 0, 0, 0);
      chk("n_load",   32'(n_load - l0),  32'(len + 1));
      chk("n_tx_req", 32'(n_txreq - t0), 32'(len));
      chk("n_rx",     32'(n_rx - r0),    32'(len + 1));
      chk("n_done",   32'(n_done - d0),  32'd1);
   endtask

   typedef struct {
      logic       rst;
      logic       st;
      logic [2:0] cr;
      logic       e_busy;
      logic       e_csn;
      logic [2:0] e_q;
   } vec_t;

   vec_t vt[8];

   initial begin
      reset = 1'b1; start = 1'b0; spicr = 3'b000; xfer_len = '0;
      sample_clk = 1'b0; shift_clk = 1'b0; tx_valid = 1'b1;

      vt[0] = '{1'b0, 1'b0, 3'b111, 1'b0, 1'b1, 3'b000};  // no request
      vt[1] = '{1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 3'b000};  // disabled: ignored
      vt[2] = '{1'b0, 1'b1, 3'b101, 1'b1, 1'b0, 3'b101};  // accepted
      vt[3] = '{1'b0, 1'b1, 3'b110, 1'b1, 1'b0, 3'b101};  // start while busy
      vt[4] = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 3'b000};  // reset aborts
      vt[5] = '{1'b1, 1'b1, 3'b111, 1'b0, 1'b1, 3'b000};  // reset beats start
      vt[6] = '{1'b0, 1'b1, 3'b111, 1'b1, 1'b0, 3'b111};
      vt[7] = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b1, 3'b000};

      repeat (3) tick(1'b0, 1'b0);
      reset = 1'b0;
      chk_out("reset", 1, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 8; i++) begin
         reset = vt[i].rst;
         start = vt[i].st;
         spicr = vt[i].cr;
         tick(1'b0, 1'b0);
         reset = 1'b0;
         chk($sformatf("vec%0d.busy", i),    32'(busy),    32'(vt[i].e_busy));
         chk($sformatf("vec%0d.cs_n", i),    32'(cs_n),    32'(vt[i].e_csn));
         chk($sformatf("vec%0d.spicr_q", i), 32'(spicr_q), 32'(vt[i].e_q));
         chk($sformatf("vec%0d.done", i),    32'(done),    32'd0);
      end
      cur_s = 3'b000;

      run_xfer(3'b100, 0, 0, 1'b0);   // single byte
      run_xfer(3'b111, 3, 0, 1'b0);   // burst, tx_valid held high
      run_xfer(3'b101, 1, 20, 1'b0);  // 20-cycle underrun

      // spicr moved to 3'b110 mid-transfer must not reach spicr_q
      start = 1'b1; spicr = 3'b100; xfer_len = '0; cur_s = 3'b100;
      tick(1'b0, 1'b0);
      spicr = 3'b110;
      repeat (GUARD) idle_tick();
      chk_out("toggle_load", 0, 0, 1, 0, 0, 1, 0);
      idle_tick();
      shift_byte(1'b0);
      repeat (GUARD - 1) idle_tick();
      idle_tick();
      chk_out("toggle_done", 1, 0, 0, 0, 0, 0, 1);
      idle_tick();

      // reset in SHIFT after 5 samples
      start = 1'b1; spicr = 3'b101; xfer_len = LEN_W'(2); cur_s = 3'b101;
      tick(1'b0, 1'b0);
      repeat (GUARD + 1) idle_tick();
      chk_out("pre_rst", 0, 1, 0, 0, 0, 1, 0);
      repeat (5) tick(1'b1, 1'b0);
      reset = 1'b1;
      tick(1'b0, 1'b0);
      reset = 1'b0;
      cur_s = 3'b000;
      chk_out("rst_shift", 1, 0, 0, 0, 0, 0, 0);
      run_xfer(3'b110, 1, 0, 1'b0);

      for (int t = 0; t < 10; t++)
         run_xfer({1'b1, 2'($urandom)}, int'($urandom % 4), -1, 1'b1);
      run_xfer({1'b1, 2'($urandom)}, (1 << LEN_W) - 1, -1, 1'b1);  // longest burst

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
